// File: rtl/reg_writeback_queue_if.sv
// Writeback request/response bundle between the execute/load pipes and the
// register-file write port, including the pending-write lookup signals.
interface reg_writeback_queue_if;
  logic        memValid;
  logic [4:0]  memDest;
  logic [31:0] memData;
  logic        memReady;
  logic        aluValid;
  logic [4:0]  aluDest;
  logic [31:0] aluData;
  logic        aluReady;
  logic        hold;
  logic        regWrite;
  logic [4:0]  destReg;
  logic [31:0] writeData;
  logic [4:0]  selA, selB, selC, selD;
  logic        pendA, pendB, pendC, pendD;
  logic        overflow;

  modport slave (
    input  memValid, memDest, memData, aluValid, aluDest, aluData, hold,
           selA, selB, selC, selD,
    output memReady, aluReady, regWrite, destReg, writeData,
           pendA, pendB, pendC, pendD, overflow
  );

  modport master (
    output memValid, memDest, memData, aluValid, aluDest, aluData, hold,
           selA, selB, selC, selD,
    input  memReady, aluReady, regWrite, destReg, writeData,
           pendA, pendB, pendC, pendD, overflow
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// Circular writeback FIFO merging load-return and ALU results into one
// register-file write port, with pending-write lookup and sticky drop flag.
module reg_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_writeback_queue_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    dest_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head, tail, alu_slot;
  logic [CW-1:0] count, free;
  logic          overflow_q;
  logic          mem_ready, alu_ready, mem_push, alu_push, pop;
  logic [PW-1:0] offset [DEPTH];
  logic [4:0]    sel [4];
  logic [3:0]    pend;

  // Outputs are forced to their idle values while reset is held so the
  // write port and lookups never expose state that is about to be cleared.
  always_comb begin
    free      = CW'(DEPTH) - count;
    mem_ready = reset || (free >= CW'(1));
    alu_ready = reset || (bus.memValid ? (free >= CW'(2)) : (free >= CW'(1)));
    mem_push  = !reset && bus.memValid && mem_ready;
    alu_push  = !reset && bus.aluValid && alu_ready;
    pop       = !reset && (count != '0) && !bus.hold;
    alu_slot  = tail + PW'(mem_push);
  end

  always_comb begin
    sel[0] = bus.selA;
    sel[1] = bus.selB;
    sel[2] = bus.selC;
    sel[3] = bus.selD;
    pend   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset[i] = PW'(i) - head;
      for (int s = 0; s < 4; s++) begin
        if (!reset && (CW'(offset[i]) < count) && (dest_q[i] == sel[s]))
          pend[s] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // Mem is older than a same-cycle ALU result, so it takes the tail slot.
      if (mem_push) begin
        dest_q[tail] <= bus.memDest;
        data_q[tail] <= bus.memData;
      end
      if (alu_push) begin
        dest_q[alu_slot] <= bus.aluDest;
        data_q[alu_slot] <= bus.aluData;
      end
      if (pop)
        head <= head + PW'(1);
      tail  <= tail + PW'(mem_push) + PW'(alu_push);
      count <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
      if ((bus.memValid && !mem_ready) || (bus.aluValid && !alu_ready))
        overflow_q <= 1'b1;
    end
  end

  assign bus.memReady  = mem_ready;
  assign bus.aluReady  = alu_ready;
  assign bus.regWrite  = pop;
  assign bus.destReg   = (!reset && count != '0) ? dest_q[head] : '0;
  assign bus.writeData = (!reset && count != '0) ? data_q[head] : '0;
  assign bus.pendA     = pend[0];
  assign bus.pendB     = pend[1];
  assign bus.pendC     = pend[2];
  assign bus.pendD     = pend[3];
  assign bus.overflow  = overflow_q;
endmodule
